// File: rtl/image_conv_requant_pkg.sv
// Shared constants, config record and clamp-bound helpers for the requantisation stage.
// PICTURE_NUM normally comes from the project-wide parameter header; a default is supplied here.
`ifndef PICTURE_NUM
`define PICTURE_NUM 2
`endif

package image_conv_requant_pkg;

    localparam int IMAGE_REQUANT_LANES = `PICTURE_NUM * 8;
    localparam int IMAGE_OUT_MIN       = 0;
    localparam int IMAGE_OUT_MAX       = 255;
    localparam int IMAGE_SHIFT_WIDTH   = 5;
    localparam int IMAGE_BOUND_WIDTH   = 10;

    typedef logic signed [IMAGE_BOUND_WIDTH-1:0] clamp_bound_t;

    typedef struct packed {
        logic [IMAGE_SHIFT_WIDTH-1:0] shift;
        logic signed [7:0]            zp;
    } requant_cfg_t;

    // Lower clamp bound for the ReLU6 variant: max(0, zp).
    function automatic clamp_bound_t relu6_lower(input logic signed [7:0] zp);
        clamp_bound_t lo;
        lo = zp[7] ? '0 : {2'b00, zp};
        return lo;
    endfunction

    // Upper clamp bound for the ReLU6 variant: min(255, zp + max), evaluated in 10 bits.
    function automatic clamp_bound_t relu6_upper(input logic signed [7:0] zp,
                                                 input logic [7:0] relu_max);
        clamp_bound_t sum;
        sum = {{2{zp[7]}}, zp} + {2'b00, relu_max};
        if (sum > clamp_bound_t'(IMAGE_OUT_MAX)) begin
            sum = clamp_bound_t'(IMAGE_OUT_MAX);
        end
        return sum;
    endfunction

endpackage

// File: rtl/image_requant_lane.sv
// One lane of the requantiser: S1 rounding arithmetic shift, S2 zero-point add and clamp.
// Both stages are plain enabled registers; flow control lives in the parent.
module image_requant_lane
    import image_conv_requant_pkg::*;
#(
    parameter int WIDTH_DATA_ADD = 32,
    parameter int WIDTH_DATA_OUT = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en1,
    input  logic                          en2,
    input  logic signed [WIDTH_DATA_ADD-1:0] x,
    input  logic [IMAGE_SHIFT_WIDTH-1:0]  shift,
    input  logic signed [7:0]             zp,
    input  clamp_bound_t                  lo,
    input  clamp_bound_t                  hi,
    output logic [WIDTH_DATA_OUT-1:0]     out
);

    // One extra bit keeps x + 2^(shift-1) from overflowing.
    localparam int WR = WIDTH_DATA_ADD + 1;
    localparam int WY = WIDTH_DATA_ADD + 2;

    logic signed [WR-1:0] x_ext;
    logic signed [WR-1:0] half;
    logic signed [WR-1:0] r_next;
    logic signed [WR-1:0] r_reg;

    logic signed [WY-1:0] r_ext;
    logic signed [WY-1:0] zp_ext;
    logic signed [WY-1:0] lo_ext;
    logic signed [WY-1:0] hi_ext;
    logic signed [WY-1:0] y;
    logic [WIDTH_DATA_OUT-1:0] out_next;
    logic [WIDTH_DATA_OUT-1:0] out_reg;

    assign x_ext = {x[WIDTH_DATA_ADD-1], x};

    always_comb begin
        half = '0;
        if (shift != '0) begin
            half = {{(WR-1){1'b0}}, 1'b1} << (shift - 5'd1);
        end
        r_next = (x_ext + half) >>> shift;
    end

    assign r_ext  = {r_reg[WR-1], r_reg};
    assign zp_ext = {{(WY-8){zp[7]}}, zp};
    assign lo_ext = {{(WY-IMAGE_BOUND_WIDTH){lo[IMAGE_BOUND_WIDTH-1]}}, lo};
    assign hi_ext = {{(WY-IMAGE_BOUND_WIDTH){hi[IMAGE_BOUND_WIDTH-1]}}, hi};
    assign y      = r_ext + zp_ext;

    always_comb begin
        out_next = y[WIDTH_DATA_OUT-1:0];
        if (y < lo_ext) begin
            out_next = lo[WIDTH_DATA_OUT-1:0];
        end else if (y > hi_ext) begin
            out_next = hi[WIDTH_DATA_OUT-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg   <= '0;
            out_reg <= '0;
        end else begin
            if (en1) begin
                r_reg <= r_next;
            end
            if (en2) begin
                out_reg <= out_next;
            end
        end
    end

    assign out = out_reg;

endmodule

// File: rtl/image_conv_requant.sv
// Requantisation stage after the per-channel scale multiplier: shift/round, zero-point, uint8 clamp.
// Optional ReLU6 clamp bounds are enabled with IMAGE_REQUANT_RELU6_EN.
module image_conv_requant
    import image_conv_requant_pkg::*;
#(
    parameter int WIDTH_DATA_ADD          = 32,
    parameter int WIDTH_DATA_OUT          = 8,
    parameter int COMPUTE_CHANNEL_OUT_NUM = 8,
    parameter int WIDTH_FEATURE_SIZE      = 10
) (
    input  logic                                                       clk,
    input  logic                                                       rst,
    input  logic [WIDTH_DATA_ADD*`PICTURE_NUM*COMPUTE_CHANNEL_OUT_NUM-1:0] s_data,
    input  logic                                                       s_valid,
    output logic                                                       s_ready,
    input  logic                                                       cfg_load,
    input  logic [IMAGE_SHIFT_WIDTH-1:0]                               cfg_shift,
    input  logic signed [7:0]                                          cfg_zp,
    input  logic [2*WIDTH_FEATURE_SIZE-1:0]                            cfg_beats,
`ifdef IMAGE_REQUANT_RELU6_EN
    input  logic [7:0]                                                 cfg_relu6_max,
`endif
    output logic                                                       cfg_idle,
    output logic [WIDTH_DATA_OUT*`PICTURE_NUM*COMPUTE_CHANNEL_OUT_NUM-1:0] m_data,
    output logic                                                       m_valid,
    input  logic                                                       m_ready,
    output logic                                                       m_last
);

    localparam int N  = `PICTURE_NUM * COMPUTE_CHANNEL_OUT_NUM;
    localparam int WB = 2 * WIDTH_FEATURE_SIZE;

    logic          v1_reg;
    logic          m_valid_reg;
    logic          m_last_reg;
    logic [WB-1:0] cnt_reg;
    logic [WB-1:0] cnt_next;
    logic [WB-1:0] beats_reg;
    logic [WB-1:0] beats_m1;
    requant_cfg_t  cfg_reg;

    logic en1;
    logic en2;
    logic handshake;
    logic cfg_accept;

    clamp_bound_t lo_bound;
    clamp_bound_t hi_bound;

    assign en2        = ~m_valid_reg | m_ready;
    assign en1        = ~v1_reg | en2;
    assign handshake  = m_valid_reg & m_ready;
    assign cfg_idle   = ~v1_reg & ~m_valid_reg;
    assign cfg_accept = cfg_load & cfg_idle;
    assign beats_m1   = beats_reg - WB'(1);

    // Beat index the next S2 occupant will carry, accounting for a same-cycle handshake.
    always_comb begin
        cnt_next = cnt_reg;
        if (handshake) begin
            cnt_next = (cnt_reg == beats_m1) ? '0 : cnt_reg + WB'(1);
        end
    end

`ifdef IMAGE_REQUANT_RELU6_EN
    logic [7:0] relu_max_reg;

    always_comb begin
        lo_bound = relu6_lower(cfg_reg.zp);
        hi_bound = relu6_upper(cfg_reg.zp, relu_max_reg);
        // A very negative zp can push the ceiling below zero; never let it cross the floor.
        if (hi_bound < lo_bound) begin
            hi_bound = lo_bound;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            relu_max_reg <= 8'hFF;
        end else if (cfg_accept) begin
            relu_max_reg <= cfg_relu6_max;
        end
    end
`else
    assign lo_bound = clamp_bound_t'(IMAGE_OUT_MIN);
    assign hi_bound = clamp_bound_t'(IMAGE_OUT_MAX);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_reg      <= 1'b0;
            m_valid_reg <= 1'b0;
            m_last_reg  <= 1'b0;
            cnt_reg     <= '0;
            cfg_reg     <= '0;
            beats_reg   <= WB'(1);
        end else begin
            if (en1) begin
                v1_reg <= s_valid;
            end
            if (en2) begin
                m_valid_reg <= v1_reg;
                m_last_reg  <= v1_reg & (cnt_next == beats_m1);
            end
            if (cfg_accept) begin
                cfg_reg.shift <= cfg_shift;
                cfg_reg.zp    <= cfg_zp;
                beats_reg     <= (cfg_beats == '0) ? WB'(1) : cfg_beats;
                cnt_reg       <= '0;
            end else begin
                cnt_reg <= cnt_next;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            image_requant_lane #(
                .WIDTH_DATA_ADD (WIDTH_DATA_ADD),
                .WIDTH_DATA_OUT (WIDTH_DATA_OUT)
            ) u_lane (
                .clk   (clk),
                .rst   (rst),
                .en1   (en1),
                .en2   (en2),
                .x     (s_data[gi*WIDTH_DATA_ADD +: WIDTH_DATA_ADD]),
                .shift (cfg_reg.shift),
                .zp    (cfg_reg.zp),
                .lo    (lo_bound),
                .hi    (hi_bound),
                .out   (m_data[gi*WIDTH_DATA_OUT +: WIDTH_DATA_OUT])
            );
        end
    endgenerate

    assign s_ready = en1;
    assign m_valid = m_valid_reg;
    assign m_last  = m_last_reg;

endmodule

// File: tb/tb_image_conv_requant.sv
// Randomised scoreboard bench for image_conv_requant with an arithmetic reference model.
// Build with IMAGE_REQUANT_RELU6_EN to exercise the ReLU6 clamp variant.
module tb_image_conv_requant;
    import image_conv_requant_pkg::*;

    localparam int L  = IMAGE_REQUANT_LANES;
    localparam int W  = 32;
    localparam int WO = 8;
    localparam int WB = 20;

    logic            clk = 1'b0;
    logic            rst;
    logic [W*L-1:0]  s_data;
    logic            s_valid;
    logic            s_ready;
    logic            cfg_load;
    logic [4:0]      cfg_shift;
    logic signed [7:0] cfg_zp;
    logic [WB-1:0]   cfg_beats;
`ifdef IMAGE_REQUANT_RELU6_EN
    logic [7:0]      cfg_relu6_max;
`endif
    logic            cfg_idle;
    logic [WO*L-1:0] m_data;
    logic            m_valid;
    logic            m_ready;
    logic            m_last;

    image_conv_requant dut (
        .clk           (clk),
        .rst           (rst),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .cfg_load      (cfg_load),
        .cfg_shift     (cfg_shift),
        .cfg_zp        (cfg_zp),
        .cfg_beats     (cfg_beats),
`ifdef IMAGE_REQUANT_RELU6_EN
        .cfg_relu6_max (cfg_relu6_max),
`endif
        .cfg_idle      (cfg_idle),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WO*L-1:0] data;
        logic            last;
    } exp_t;

    exp_t exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    // Reference configuration and beat position, mirrored from what the bench loaded.
    int m_shift  = 0;
    int m_zp     = 0;
    int m_beats  = 1;
    int m_relu   = 255;
    int beat_idx = 0;
    int mr_mode  = 0;
    int mr_phase = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_lane(input longint x);
        longint d, v, r, y, lo, hi;
        if (m_shift == 0) begin
            r = x;
        end else begin
            d = longint'(1) << m_shift;
            v = x + d / 2;
            r = (v >= 0) ? v / d : -(((-v) + d - 1) / d);
        end
        y  = r + m_zp;
        lo = 0;
        hi = 255;
`ifdef IMAGE_REQUANT_RELU6_EN
        lo = (m_zp > 0) ? m_zp : 0;
        hi = m_zp + m_relu;
        if (hi > 255) hi = 255;
        if (hi < lo)  hi = lo;
`endif
        if (y < lo) y = lo;
        if (y > hi) y = hi;
        return 8'(y);
    endfunction

    function automatic exp_t model_beat(input logic [W*L-1:0] d);
        exp_t e;
        logic [W-1:0] w;
        for (int k = 0; k < L; k++) begin
            w = d[k*W +: W];
            e.data[k*WO +: WO] = ref_lane(longint'($signed(w)));
        end
        e.last   = (beat_idx == m_beats - 1);
        beat_idx = e.last ? 0 : beat_idx + 1;
        return e;
    endfunction

    function automatic logic next_mready();
        logic r;
        mr_phase++;
        case (mr_mode)
            0:       r = 1'b1;
            1:       r = ((mr_phase % 3) == 1);
            2:       r = ($urandom_range(0, 3) != 0);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [W-1:0] rand_lane();
        int t;
        case ($urandom_range(0, 2))
            0:       t = int'($urandom);
            1:       t = int'($urandom_range(0, 8000)) - 4000;
            default: t = int'($urandom_range(0, 1 << 20)) - (1 << 19);
        endcase
        return 32'(t);
    endfunction

    function automatic logic [W*L-1:0] rand_beat();
        logic [W*L-1:0] d;
        for (int k = 0; k < L; k++) d[k*W +: W] = rand_lane();
        return d;
    endfunction

    function automatic logic [W*L-1:0] fill_beat(input logic [W-1:0] x);
        logic [W*L-1:0] d;
        for (int k = 0; k < L; k++) d[k*W +: W] = x;
        return d;
    endfunction

    task automatic cycle(input logic v, input logic [W*L-1:0] d, output logic acc);
        @(negedge clk);
        s_valid = v;
        s_data  = d;
        m_ready = next_mready();
        #1;
        acc = v & s_ready;
        @(posedge clk);
        if (acc) exp_q.push_back(model_beat(d));
    endtask

    task automatic send(input logic [W*L-1:0] d);
        logic acc;
        int   n;
        n = 0;
        do begin
            cycle(1'b1, d, acc);
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("send_timeout", 64'(acc), 64'd1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, acc);
    endtask

    task automatic do_cfg(input int sh, input int zp, input int beats, input int relu);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            s_valid = 1'b0;
            m_ready = 1'b1;
            #1;
            n++;
        end while (!cfg_idle && n < 100);
        if (!cfg_idle) chk("cfg_idle_timeout", 64'(cfg_idle), 64'd1);
        cfg_load  = 1'b1;
        cfg_shift = 5'(sh);
        cfg_zp    = 8'(zp);
        cfg_beats = WB'(beats);
`ifdef IMAGE_REQUANT_RELU6_EN
        cfg_relu6_max = 8'(relu);
`endif
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        m_shift  = sh;
        m_zp     = zp;
        m_beats  = (beats == 0) ? 1 : beats;
`ifdef IMAGE_REQUANT_RELU6_EN
        m_relu   = relu;
`endif
        beat_idx = 0;
    endtask

    // Monitor: samples between clock edges, checks flow control, output hold and scoreboard.
    logic            held_valid = 1'b0;
    logic [WO*L-1:0] held_data;
    logic            held_last;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                held_valid = 1'b0;
            end else begin
                chk("s_ready", 64'(s_ready), 64'(!(exp_q.size() >= 2 && !m_ready)));
                if (held_valid) begin
                    vectors++;
                    if (!m_valid || m_data !== held_data || m_last !== held_last) begin
                        miscompares++;
                        $display("FAIL hold: got v=%0b last=%0b %h expected v=1 last=%0b %h",
                                 m_valid, m_last, m_data, held_last, held_data);
                    end
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 64'(m_valid), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        vectors++;
                        if (m_data !== e.data) begin
                            miscompares++;
                            $display("FAIL data: got %h expected %h", m_data, e.data);
                        end
                        chk("last", 64'(m_last), 64'(e.last));
                    end
                end
                held_valid = m_valid && !m_ready;
                held_data  = m_data;
                held_last  = m_last;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W*L-1:0] d;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        cfg_load = 1'b0; cfg_shift = '0; cfg_zp = '0; cfg_beats = '0;
`ifdef IMAGE_REQUANT_RELU6_EN
        cfg_relu6_max = '0;
`endif
        repeat (3) @(negedge clk);
        #2;
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_m_data", 64'(m_data[63:0]), 64'd0);
        chk("rst_cfg_idle", 64'(cfg_idle), 64'd1);
        @(negedge clk);
        #1 rst = 1'b0;

        // Rounding half toward +inf, plus two-cycle latency
        do_cfg(8, 0, 0, 255);
        mr_mode = 0;
        d = rand_beat(); d[W-1:0] = 32'h0000_0180;
        send(d);
        @(negedge clk);
        s_valid = 1'b0;
        #2 chk("latency_c1", 64'(m_valid), 64'd0);
        @(negedge clk);
        #2 chk("latency_c2", 64'(m_valid), 64'd1);
        d = rand_beat(); d[W-1:0] = 32'h0000_017F;
        send(d);
        idle(3);

        // Clamp low / clamp high / in-range
        do_cfg(4, -10, 0, 255);
        send(fill_beat(32'hFFFF_F000));
        do_cfg(4, 5, 0, 255);
        send(fill_beat(32'h0010_0000));
        do_cfg(4, 10, 0, 255);
        send(fill_beat(32'h0000_0320));
        idle(3);

        // Backpressure with a 1,0,0 ready pattern
        do_cfg(3, 7, 4, 255);
        mr_mode = 1; mr_phase = 0;
        for (int i = 0; i < 6; i++) send(rand_beat());
        idle(10);

        // A cfg_load while the output is stalled must be ignored
        mr_mode = 3;
        send(rand_beat());
        idle(2);
        @(negedge clk);
        s_valid = 1'b0; m_ready = 1'b0;
        cfg_load = 1'b1; cfg_shift = 5'd31; cfg_zp = 8'sd100; cfg_beats = WB'(2);
        @(posedge clk);
        #1 cfg_load = 1'b0;
        mr_mode = 0;
        send(rand_beat());
        idle(3);

        // m_last placement
        do_cfg(2, 0, 3, 255);
        for (int i = 0; i < 7; i++) send(rand_beat());
        do_cfg(0, -3, 0, 255);
        for (int i = 0; i < 4; i++) send(rand_beat());
        idle(3);

        // Randomised segments
        for (int seg = 0; seg < 6; seg++) begin
            do_cfg(int'($urandom_range(0, 31)), int'($urandom_range(0, 255)) - 128,
                   int'($urandom_range(0, 5)), int'($urandom_range(0, 255)));
            mr_mode = int'($urandom_range(0, 2));
            for (int i = 0; i < 30; i++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                send(rand_beat());
            end
        end
        mr_mode = 0;
        idle(4);

        // Async reset with two beats in flight
        do_cfg(6, 20, 2, 255);
        mr_mode = 3;
        send(rand_beat());
        send(rand_beat());
        @(negedge clk);
        s_valid = 1'b0; m_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("arst_m_valid", 64'(m_valid), 64'd0);
        chk("arst_cfg_idle", 64'(cfg_idle), 64'd1);
        exp_q.delete();
        m_shift = 0; m_zp = 0; m_beats = 1; m_relu = 255; beat_idx = 0;
        @(negedge clk);
        #1 rst = 1'b0;
        mr_mode = 0;
        send(fill_beat(32'd200));
        idle(3);

`ifdef IMAGE_REQUANT_RELU6_EN
        do_cfg(0, 10, 0, 60);
        send(fill_beat(32'd100));
        send(fill_beat(32'hFFFF_FFCE));
        idle(3);
`endif

        mr_mode = 0;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1);
        chk("drain", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/image_conv_requant.md
Name: image_conv_requant

Overview:
- Stage directly downstream of the per-channel scale multiplier in the image convolution path.
- Takes the 32-bit scaled products for all lanes (PICTURE_NUM x COMPUTE_CHANNEL_OUT_NUM) and applies the remaining requantisation steps:
  - rounding arithmetic right shift,
  - zero-point add,
  - saturation to uint8.
- Output is a valid/ready stream with backpressure and a per-feature-map last flag, ready for the output FIFO/writeback stage.

Parameters:
- WIDTH_DATA_ADD, 32, per-lane signed input width (scale multiplier output).
- WIDTH_DATA_OUT, 8, per-lane unsigned output width.
- COMPUTE_CHANNEL_OUT_NUM, 8, output channels per beat. Lanes per beat N = `PICTURE_NUM*COMPUTE_CHANNEL_OUT_NUM.
- WIDTH_FEATURE_SIZE, 10, feature-map dimension width. The beat counter is 2*WIDTH_FEATURE_SIZE bits wide.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- s_data  in  WIDTH_DATA_ADD*N  signed lanes. Lane k=j*`PICTURE_NUM+i occupies bits [(k+1)*WIDTH_DATA_ADD-1 : k*WIDTH_DATA_ADD].
- s_valid  in  1  s_data valid (aligned by caller to multiplier latency).
- s_ready  out  1  block accepts s_data this cycle.
- cfg_load  in  1  one-cycle pulse; latch cfg_shift, cfg_zp, cfg_beats.
- cfg_shift  in  5  right-shift amount, 0..31.
- cfg_zp  in  8  signed output zero point.
- cfg_beats  in  2*WIDTH_FEATURE_SIZE  beats per feature map.
- cfg_idle  out  1  high when both pipeline stages and the output are empty.
- m_data  out  WIDTH_DATA_OUT*N  uint8 lanes, same lane packing as s_data.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accepts.
- m_last  out  1  final beat of feature map.

Behaviour:
- Reset (async, rst=1): clear the following, all effective immediately and independent of clk:
  - v1, m_valid, m_last, m_data, beat counter;
  - shift/zp/beats registers (beats reg resets to 1).
  - In-flight beats are discarded; no partial output after release.
- Pipeline has two registered stages: S1 = shift/round, S2 = zp/clamp (the output register).
  - en2 = ~m_valid | m_ready.
  - en1 = ~v1 | en2.
  - s_ready = en1 (combinational).
  - Bubbles collapse.
  - Latency is 2 cycles from accepted s_valid to m_valid with m_ready held high; throughput is 1 beat/cycle.
- S1 (per lane, x signed 32-bit), computed in 33 bits so there is no overflow:
  - shift=0: r=x.
  - else: r=(x + 2^(shift-1)) >>> shift, i.e. round half toward +inf.
- S2 (per lane):
  - y = r + sign-extended zp.
  - out = 0 if y<0, 255 if y>255, else y[7:0].
- Output hold: m_data, m_valid and m_last hold stable while m_valid & ~m_ready (AXI-stream rules).
- Beat counter:
  - Increments on m_valid & m_ready.
  - m_last = (counter == beats-1) whenever m_valid.
  - On the last handshake the counter wraps to 0.
  - cfg_beats=0 is latched as 1, so every beat is last.
- cfg_load:
  - Legal only when cfg_idle=1 and s_valid=0.
  - Latches all three config fields and zeroes the counter.
  - If asserted while cfg_idle=0, it is ignored and config is unchanged.
- Simultaneous events:
  - A beat entering S1 while another leaves S2 in the same cycle is a normal transfer.
  - With m_ready low and v1 set, s_ready=0, and S1 holds its value.

Optional Feature:
- Macro IMAGE_REQUANT_RELU6_EN.
- Defined:
  - Adds input cfg_relu6_max[7:0], latched on cfg_load.
  - The S2 upper clamp bound becomes min(255, zp + cfg_relu6_max), computed in 10 bits.
  - The lower bound becomes max(0, zp).
- Undefined: the port is absent and the bounds are fixed at 0/255.

Decomposition:
- Shared package / Para.v additions:
  - IMAGE_REQUANT_LANES (= `PICTURE_NUM*COMPUTE_CHANNEL_OUT_NUM),
  - IMAGE_OUT_MIN=0, IMAGE_OUT_MAX=255,
  - shift width 5.
- Sub-module image_requant_lane:
  - One lane's S1/S2 datapath with its two data registers, enabled by en1/en2.
  - Instantiated N times in a generate loop.
- Valid/ready control, config registers and the beat counter live in the top.

Test Plan:
- shift=8, zp=0, lane x=0x00000180 (384) -> 2 cycles later out=2 (384/256=1.5 rounds up); x=0x0000017F -> 1.
- shift=4, zp=-10, x=-0x1000 -> 0 (clamp low); x=0x00100000, zp=5 -> 255 (clamp high); x=0x00000320 -> 60.
- Backpressure: stream 6 beats with m_ready toggling 1,0,0,1,... -> all 6 outputs appear in order, none lost or duplicated, m_data stable while stalled, s_ready low when both stages full.
- cfg_beats=3, 7 beats -> m_last on beats 3 and 6 only; cfg_beats=0 -> m_last on every beat.
- Assert rst for 1 cycle while 2 beats are in flight -> m_valid=0 immediately, cfg_idle=1, config back to shift=0/zp=0; the next beat x=200 emits 200.
- With IMAGE_REQUANT_RELU6_EN: zp=10, relu6_max=60, x=100 (shift=0) -> 70; x=-50 -> 10.
